// File: rtl/relu_channel_scheduler.sv
// Streams NUM_CH x MAP_X x MAP_Y feature-map elements through a shared ReLU into a 2-entry output FIFO.
// Optional clamped-element counter enabled by defining RELU_ZERO_CNT_EN.
module relu_channel_scheduler #(
    parameter int NUM_CH     = 8,
    parameter int MAP_X      = 24,
    parameter int MAP_Y      = 24,
    parameter int DATA_WIDTH = 45,
    localparam int CW = $clog2(NUM_CH),
    localparam int XW = $clog2(MAP_X),
    localparam int YW = $clog2(MAP_Y),
    localparam int ZW = $clog2(NUM_CH * MAP_X * MAP_Y + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [CW-1:0]         rd_ch,
    output logic [XW-1:0]         rd_x,
    output logic [YW-1:0]         rd_y,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         out_ch,
    output logic [XW-1:0]         out_x,
    output logic [YW-1:0]         out_y,
    output logic                  out_last,
    output logic [ZW-1:0]         zero_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [CW-1:0]         ch;
        logic [XW-1:0]         x;
        logic [YW-1:0]         y;
        logic                  last;
    } entry_t;

    state_t        state, state_n;
    logic [CW-1:0] ch_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          inflight;
    logic [CW-1:0] inf_ch;
    logic [XW-1:0] inf_x;
    logic [YW-1:0] inf_y;
    logic          inf_last;
    entry_t        mem [2];
    entry_t        wr_entry, head;
    logic          rd_ptr, wr_ptr;
    logic [1:0]    count;
    logic          active, abort_hit, accept, pop, wr, issue_ok, last_addr;

    assign active    = (state == RUN) || (state == DRAIN);
    assign abort_hit = abort && active;
    assign accept    = (state == IDLE) && start && !abort;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign wr        = inflight && !abort_hit;
    // Occupancy after this cycle's pop must leave room for the read being issued.
    assign issue_ok  = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    assign rd_en     = (state == RUN) && !abort && issue_ok;
    assign last_addr = (ch_q == CW'(NUM_CH - 1)) && (x_q == XW'(MAP_X - 1)) && (y_q == YW'(MAP_Y - 1));
    assign busy      = active;
    assign done      = (state == DONE);
    assign rd_ch     = ch_q;
    assign rd_x      = x_q;
    assign rd_y      = y_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = RUN;
            RUN:     if (abort) state_n = IDLE;
                     else if (rd_en && last_addr) state_n = DRAIN;
            // Leave as soon as the FIFO will be empty after this cycle's pop.
            DRAIN:   if (abort) state_n = IDLE;
                     else if (!inflight && (count == {1'b0, pop})) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
        end else if (accept) begin
            ch_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
        end else if (rd_en) begin
            if (y_q == YW'(MAP_Y - 1)) begin
                y_q <= '0;
                if (x_q == XW'(MAP_X - 1)) begin
                    x_q  <= '0;
                    ch_q <= (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end else begin
                y_q <= y_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= 1'b0;
            inf_ch   <= '0;
            inf_x    <= '0;
            inf_y    <= '0;
            inf_last <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                inf_ch   <= ch_q;
                inf_x    <= x_q;
                inf_y    <= y_q;
                inf_last <= last_addr;
            end
        end
    end

    always_comb begin
        wr_entry      = '0;
        wr_entry.data = rd_data[DATA_WIDTH-1] ? '0 : rd_data;
        wr_entry.ch   = inf_ch;
        wr_entry.x    = inf_x;
        wr_entry.y    = inf_y;
        wr_entry.last = inf_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (abort_hit) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, wr} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_entry;
    end

    always_comb begin
        head = mem[rd_ptr];
        if (!out_valid) head = '0;
    end

    assign out_data = head.data;
    assign out_ch   = head.ch;
    assign out_x    = head.x;
    assign out_y    = head.y;
    assign out_last = head.last;

`ifdef RELU_ZERO_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                 zero_cnt <= '0;
        else if (accept)                          zero_cnt <= '0;
        else if (wr && rd_data[DATA_WIDTH-1])     zero_cnt <= zero_cnt + 1'b1;
    end
`else
    assign zero_cnt = '0;
`endif

endmodule

// File: tb/tb_relu_channel_scheduler.sv
// Directed bench for relu_channel_scheduler: buffer model, ReLU/coordinate scoreboard, timing and abort/reset checks.
module tb_relu_channel_scheduler;

    localparam int N = 4608;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic [44:0] rd_data = '0;
    logic        busy, done, rd_en, out_valid, out_last;
    logic [2:0]  rd_ch, out_ch;
    logic [4:0]  rd_x, rd_y, out_x, out_y;
    logic [44:0] out_data;
    logic [12:0] zero_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          mode = 0;
    int          rmode = 1;
    logic        mon_en = 1'b0;
    int unsigned exp_idx = 0;
    int          issued = 0;
    int          popped = 0;
    int          done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [44:0] prev_data = '0;
    logic [12:0] prev_coord = '0;

    relu_channel_scheduler #(.NUM_CH(8), .MAP_X(24), .MAP_Y(24), .DATA_WIDTH(45)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_x(out_x), .out_y(out_y), .out_last(out_last),
        .zero_cnt(zero_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [44:0] elem(input int unsigned i, input int m);
        case (m)
            0: return 45'(i);
            1: return '1;
            2: return (i % 3 == 0) ? 45'(0) - 45'(i) : 45'(i);
            default: case (i % 3)
                0: return 45'h0FFF_FFFF_FFFF;
                1: return 45'h1000_0000_0000;
                default: return 45'h0;
            endcase
        endcase
    endfunction

    function automatic logic [44:0] relu_exp(input int unsigned i, input int m);
        case (m)
            0: return 45'(i);
            1: return 45'h0;
            2: return (i % 3 == 0) ? 45'h0 : 45'(i);
            default: return (i % 3 == 0) ? 45'h0FFF_FFFF_FFFF : 45'h0;
        endcase
    endfunction

    function automatic logic [12:0] coord_of(input int unsigned i);
        return {3'(i / 576), 5'((i / 24) % 24), 5'(i % 24)};
    endfunction

    function automatic logic [63:0] zx(input int n);
`ifdef RELU_ZERO_CNT_EN
        return 64'(n);
`else
        return 64'(n - n);
`endif
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 9) < 3);
        endcase
    end

    // Buffer model: read data appears one cycle after the strobe.
    initial forever begin
        logic        req;
        int unsigned idx;
        @(negedge clk);
        req = rd_en;
        idx = int'(rd_ch) * 576 + int'(rd_x) * 24 + int'(rd_y);
        @(posedge clk);
        #1;
        if (req) rd_data = elem(idx, mode);
    end

    initial forever begin
        @(negedge clk);
        if (mon_en && rst) begin
            check("outstanding_le2", 64'((issued - popped) > 2), 64'd0);
            if (prev_stall && busy) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_coord", 64'({out_ch, out_x, out_y}), 64'(prev_coord));
            end
            if (out_valid && out_ready) begin
                check("out_data", 64'(out_data), 64'(relu_exp(exp_idx, mode)));
                check("out_coord", 64'({out_ch, out_x, out_y}), 64'(coord_of(exp_idx)));
                check("out_last", 64'(out_last), 64'(exp_idx == N - 1));
                exp_idx++;
                popped++;
            end
            if (rd_en) issued++;
            if (done) done_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_coord = {out_ch, out_x, out_y};
        end
    end

    task automatic clear_board(input int m, input int rm);
        mode       = m;
        rmode      = rm;
        exp_idx    = 0;
        issued     = 0;
        popped     = 0;
        done_cnt   = 0;
        prev_stall = 1'b0;
    endtask

    task automatic run_pass(input int m, input int rm, input int restart_at, input logic [63:0] zexp);
        int t0;
        int n;
        clear_board(m, rm);
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_T1", 64'(busy), 64'd1);
        check("rd_en_T1", 64'(rd_en), 64'd1);
        @(negedge clk);
        check("valid_T2", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("valid_T3", 64'(out_valid), 64'd1);
        n = 0;
        while (!done && n < 30000) begin
            @(negedge clk);
            n++;
            start = (restart_at != 0) && (n == restart_at);
        end
        start = 1'b0;
        check("done_seen", 64'(done), 64'd1);
        if (rm == 1) check("done_latency", 64'(cyc - t0), 64'd4611);
        check("pop_count", 64'(popped), 64'(N));
        check("zero_cnt", 64'(zero_cnt), zexp);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        check("done_pulses", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_addr", 64'({rd_ch, rd_x, rd_y}), 64'd0);
        check("rst_zero_cnt", 64'(zero_cnt), 64'd0);
        rst = 1'b1;
        mon_en = 1'b1;

        run_pass(0, 1, 0, 64'd0);
        run_pass(1, 1, 0, zx(N));
        run_pass(2, 2, 0, zx(1535));
        run_pass(3, 1, 0, zx(1536));

        // Abort after ~1000 elements while stalled.
        clear_board(2, 1);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (popped < 1000 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached", 64'(n < 5000), 64'd1);
        rmode = 0;
        repeat (4) @(negedge clk);
        check("abort_stalled_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_rd_en", 64'(rd_en), 64'd0);
        rmode = 1;
        repeat (20) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'd0);

        // Abort wins over start in IDLE.
        @(posedge clk); #1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", 64'(busy), 64'd0);
        check("idle_abort_rd_en", 64'(rd_en), 64'd0);

        run_pass(0, 1, 0, 64'd0);

        // Reset mid-pass.
        clear_board(0, 1);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (100) @(negedge clk);
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rd_en", 64'(rd_en), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_addr", 64'({rd_ch, rd_x, rd_y}), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_zero_cnt", 64'(zero_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        run_pass(2, 1, 50, zx(1535));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/relu_channel_scheduler.md
# relu_channel_scheduler

Sequencer that streams the eight stored convolution feature maps through a single shared ReLU datapath, one element per cycle. It sits between the convolution result buffer and the pooling stage. It generates buffer read addresses, applies ReLU, and delivers results over a valid/ready stream with backpressure. It reports progress via `busy`/`done` to the top-level layer controller.

## Interface
- `NUM_CH`, 8, number of feature-map channels
- `MAP_X`, 24, rows per map
- `MAP_Y`, 24, columns per map
- `DATA_WIDTH`, 45, signed two's-complement element width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a full pass; honoured only in IDLE
- `abort`  in  1  synchronous abandon of the current pass
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle pulse at pass completion
- `rd_en`  out  1  buffer read strobe; data returns exactly 1 cycle later
- `rd_ch`  out  $clog2(NUM_CH)  channel address (3 bits at default)
- `rd_x`  out  $clog2(MAP_X)  row address (5 bits at default)
- `rd_y`  out  $clog2(MAP_Y)  column address (5 bits at default)
- `rd_data`  in  DATA_WIDTH  buffer read data
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream accepts
- `out_data`  out  DATA_WIDTH  ReLU result
- `out_ch`/`out_x`/`out_y`  out  as rd_*  coordinates of `out_data`
- `out_last`  out  1  marks element (NUM_CH-1, MAP_X-1, MAP_Y-1)
- `zero_cnt`  out  $clog2(NUM_CH*MAP_X*MAP_Y+1)  count of clamped elements (13 bits at default)

## Operation
- FSM states are IDLE, RUN, DRAIN, and DONE.
- IDLE -> RUN on `start`. The address counters clear to (0,0,0).
- RUN: `rd_en` asserts when issue is allowed: `fifo_count + inflight - pop < 2`, where `pop = out_valid & out_ready`.
- Each issue advances the address in this order: y fastest, then x, then ch. Wrap happens at MAP_Y-1, MAP_X-1, NUM_CH-1.
- RUN -> DRAIN after the last address is issued.
- DRAIN -> DONE when the FIFO is empty and nothing is in flight.
- DONE lasts one cycle: `done`=1, then the FSM returns to IDLE.
- ReLU is applied at FIFO write: if `rd_data[DATA_WIDTH-1]` is 1, the stored value is 0; otherwise it is `rd_data` unchanged. No width change occurs.
- Coordinates travel with the data through a 2-entry FIFO. The FIFO head drives the `out_*` ports.
- `out_*` stays stable while `out_valid & !out_ready`.
- `abort` in RUN or DRAIN returns the FSM to IDLE next cycle.
  - The FIFO is flushed and the in-flight read is discarded.
  - `done` is not pulsed and `zero_cnt` is held.
- `abort` in IDLE has no effect. `abort` and `start` in the same IDLE cycle: `abort` wins and the FSM stays in IDLE.
- `start` while busy is ignored.

## Timing
- All outputs reset to 0: state IDLE, FIFO empty, counters 0.
- Reset mid-pass aborts immediately, with no `done` and no partial-state retention.
- `start` at cycle T gives `rd_en` at T+1, FIFO write at T+2, and `out_valid` at T+3.
- With `out_ready` held at 1, throughput is one element per cycle. The last handshake occurs at T+2+N, where N = NUM_CH·MAP_X·MAP_Y = 4608.
- `done` pulses in the cycle after the FIFO empties following the `out_last` handshake.
- Under `out_ready`=0 at most 2 elements are buffered, with no loss and no duplication. Issue resumes in the same cycle a pop occurs.
- `busy` rises at T+1 and falls in the DONE cycle.

## Configuration
- Macro: `RELU_ZERO_CNT_EN`.
- When defined:
  - `zero_cnt` clears on accepted `start`.
  - `zero_cnt` increments on each FIFO write whose input sign bit is 1.
  - The final value is valid from the `done` cycle until the next `start`.
- When undefined: the counter logic is removed and `zero_cnt` is tied to 0. The port remains present.

## Test plan
- Full pass, `out_ready`=1, channel c element (x,y) = +(c·576+x·24+y) -> 4608 outputs in order, values unchanged, `out_last` only on (7,23,23), `done` one cycle at T+4611.
- All elements = -1 (all ones) -> every `out_data`=0; with `RELU_ZERO_CNT_EN`, `zero_cnt`=4608; without it, `zero_cnt`=0.
- Random `out_ready` at 30% duty with mixed-sign data -> output sequence identical to the model, at most 2 buffered, `out_*` stable while stalled.
- Edge values: 45'h0FFF_FFFF_FFFF -> passed unchanged; 45'h1000_0000_0000 -> 0; 0 -> 0 and not counted.
- `abort` at element 1000 with `out_ready`=0 -> IDLE next cycle, `out_valid`=0, no `done`; a following `start` restarts at (0,0,0).
- `rst` low mid-pass and `start` while busy -> all outputs 0 immediately; a second `start` during RUN does not reset the addresses.
